// File: rtl/uart_rx_buffered.sv
// uart_rx_buffered
// Receives 8N1 serial frames and queues the data bytes for a downstream consumer.
// The line is synchronised through two flops. A start bit must still be low at
// mid-bit, or it is treated as a glitch and ignored. Every bit is decided by a
// 2-of-3 majority vote around mid-bit. A low stop bit is reported as a framing
// error. Good bytes go into a small first-word-fall-through FIFO.
//
// Ports:
//   clk           system clock, all logic on the rising edge
//   reset         synchronous, active-low reset
//   serial_in     asynchronous serial line, idle high
//   parallel_out  FIFO head byte, valid while rx_valid is high
//   rx_valid      FIFO holds at least one byte
//   rx_ready      consumer takes the head byte when rx_valid is also high
//   frame_err     one-cycle pulse: stop bit sampled low
//   overrun       one-cycle pulse: good byte dropped because the FIFO was full
//   fifo_count    current FIFO occupancy
module uart_rx_buffered #(
    parameter int CLK_HZ       = 100000000,
    parameter int BIT_RATE     = 115200,
    parameter int PAYLOAD_BITS = 8,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          serial_in,
    output logic [PAYLOAD_BITS-1:0]       parallel_out,
    output logic                          rx_valid,
    input  logic                          rx_ready,
    output logic                          frame_err,
    output logic                          overrun,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int CLKS_PER_BIT = CLK_HZ / BIT_RATE;
    localparam int HALF         = CLKS_PER_BIT / 2;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);
    localparam int IDX_W        = (PAYLOAD_BITS > 1) ? $clog2(PAYLOAD_BITS) : 1;
    localparam int PTR_W        = $clog2(FIFO_DEPTH);
    localparam int OCC_W        = PTR_W + 1;

    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_SAMP0  = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] CNT_SAMP1  = CNT_W'(HALF);
    localparam logic [CNT_W-1:0] CNT_VOTE   = CNT_W'(HALF + 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(PAYLOAD_BITS - 1);
    localparam logic [OCC_W-1:0] OCC_FULL   = OCC_W'(FIFO_DEPTH);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;

    state_t                  state, state_next;
    logic                    sync1, sync2;
    logic [CNT_W-1:0]        cnt, cnt_next;
    logic [IDX_W-1:0]        bit_idx, bit_idx_next;
    logic [PAYLOAD_BITS-1:0] shift, shift_next;
    logic [1:0]              samples, samples_next;
    logic                    frame_err_next, overrun_next;
    logic                    vote, at_vote, at_end;
    logic                    push, pop, full;

    logic [PAYLOAD_BITS-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]        rd_ptr, wr_ptr;
    logic [OCC_W-1:0]        count;

    assign rx_valid     = (count != '0);
    assign full         = (count == OCC_FULL);
    assign pop          = rx_valid && rx_ready;
    assign fifo_count   = count;
    assign parallel_out = mem[rd_ptr];

    // Synchroniser, FSM state and the registered error pulses.
    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1     <= 1'b1;
            sync2     <= 1'b1;
            state     <= IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shift     <= '0;
            samples   <= 2'b11;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            sync1     <= serial_in;
            sync2     <= sync1;
            state     <= state_next;
            cnt       <= cnt_next;
            bit_idx   <= bit_idx_next;
            shift     <= shift_next;
            samples   <= samples_next;
            frame_err <= frame_err_next;
            overrun   <= overrun_next;
        end
    end

    // The first two samples are held in registers. The third is the live sync2
    // at the vote cycle, so the 2-of-3 result is available at cnt == HALF+1.
    always_comb begin
        state_next     = state;
        bit_idx_next   = bit_idx;
        shift_next     = shift;
        samples_next   = samples;
        frame_err_next = 1'b0;
        overrun_next   = 1'b0;
        push           = 1'b0;
        cnt_next       = '0;
        at_end         = (cnt == CNT_LAST);
        at_vote        = (cnt == CNT_VOTE);
        vote           = (samples[0] & samples[1]) | (samples[0] & sync2) | (samples[1] & sync2);

        if (cnt == CNT_SAMP0) samples_next[0] = sync2;
        if (cnt == CNT_SAMP1) samples_next[1] = sync2;

        case (state)
            IDLE: begin
                if (!sync2) state_next = START;
            end
            START: begin
                if (at_vote && vote) begin
                    state_next = IDLE;
                end else if (at_end) begin
                    state_next   = DATA;
                    bit_idx_next = '0;
                end
            end
            DATA: begin
                if (at_vote) shift_next = {vote, shift[PAYLOAD_BITS-1:1]};
                if (at_end) begin
                    if (bit_idx == IDX_LAST) state_next = STOP;
                    else bit_idx_next = bit_idx + 1'b1;
                end
            end
            STOP: begin
                // The decision is made at mid stop bit, so a slightly fast
                // transmitter's next start bit is not missed.
                if (at_vote) begin
                    if (vote) begin
                        // A simultaneous pop frees a slot even when the FIFO is full.
                        if (!full || pop) push = 1'b1;
                        else overrun_next = 1'b1;
                        state_next = IDLE;
                    end else begin
                        frame_err_next = 1'b1;
                        state_next     = WAIT_IDLE;
                    end
                end
            end
            WAIT_IDLE: begin
                if (sync2) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase

        if (state_next == state && !at_end) cnt_next = cnt + 1'b1;
    end

    // Circular FIFO. The pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= shift;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_buffered.sv
// tb_uart_rx_buffered
// Bench for uart_rx_buffered. The bit rate is raised to 100 clocks per bit so the
// whole run stays short.
// - A table of frames is sent with the consumer always ready.
// - Hand-written sequences cover the glitch case, overrun, the full-FIFO
//   push/pop collision and reset in the middle of a frame.
// - Expected bytes go into a queue as each frame is sent. A negedge monitor pops
//   the queue on every accepted handshake and compares the byte.
module tb_uart_rx_buffered;

    localparam int CLK_HZ   = 100000000;
    localparam int BIT_RATE = 1000000;
    localparam int CPB      = CLK_HZ / BIT_RATE;
    localparam int HALF     = CPB / 2;
    // The line is driven low just after an edge. The FSM first sees sync2 low
    // three edges later (S). rx_valid is visible after edge S+9*CPB+HALF+2.
    localparam int LAT      = 9 * CPB + HALF + 5;

    typedef struct {
        logic [7:0] data;
        logic       stop_bit;
        int         hold_low;
        int         gap;
        logic       accept;
        int         exp_ferr;
        int         exp_ovr;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       serial_in;
    logic [7:0] parallel_out;
    logic       rx_valid;
    logic       rx_ready;
    logic       frame_err;
    logic       overrun;
    logic [2:0] fifo_count;

    int         checks = 0;
    int         errors = 0;
    int         cycle = 0;
    int         frame_start = 0;
    int         last_rise = -1;
    int         ferr_cycles = 0;
    int         ovr_cycles = 0;
    int         ferr0, ovr0;
    logic       valid_d = 1'b0;
    logic [7:0] sb [$];
    vec_t       vecs [6];
    vec_t       v;

    uart_rx_buffered #(
        .CLK_HZ(CLK_HZ),
        .BIT_RATE(BIT_RATE),
        .PAYLOAD_BITS(8),
        .FIFO_DEPTH(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .serial_in(serial_in),
        .parallel_out(parallel_out),
        .rx_valid(rx_valid),
        .rx_ready(rx_ready),
        .frame_err(frame_err),
        .overrun(overrun),
        .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic check_output(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d (0x%0h), required %0d (0x%0h)", name, actual, actual, expected, expected);
        end
    endtask

    // Scoreboard monitor: it samples at the negedge, away from the active edge.
    always @(negedge clk) begin
        if (frame_err) ferr_cycles++;
        if (overrun) ovr_cycles++;
        if (rx_valid && !valid_d) last_rise = cycle;
        valid_d = rx_valid;
        if (rx_valid && rx_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_byte: got 0x%02h, required no byte", parallel_out);
            end else begin
                check_output("rx_byte", int'(parallel_out), int'(sb.pop_front()));
            end
        end
    end

    // Inputs change 2 time units after a rising edge.
    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) @(posedge clk);
        #2;
    endtask

    task automatic apply_stimulus(input vec_t s);
        logic [9:0] bits;
        bits = {s.stop_bit, s.data, 1'b0};
        frame_start = cycle;
        if (s.accept) sb.push_back(s.data);
        for (int i = 0; i < 10; i++) begin
            serial_in = bits[i];
            wait_cycles(CPB);
        end
        if (s.hold_low > 0) begin
            serial_in = 1'b0;
            wait_cycles(s.hold_low * CPB);
        end
        serial_in = 1'b1;
        wait_cycles(s.gap * CPB);
    endtask

    function automatic int rise_latency();
        return (last_rise < 0) ? -1 : last_rise - frame_start;
    endfunction

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vecs[0] = '{data: 8'h55, stop_bit: 1'b1, hold_low: 0, gap: 2, accept: 1'b1, exp_ferr: 0, exp_ovr: 0};
        vecs[1] = '{data: 8'h00, stop_bit: 1'b1, hold_low: 0, gap: 2, accept: 1'b1, exp_ferr: 0, exp_ovr: 0};
        vecs[2] = '{data: 8'hFF, stop_bit: 1'b1, hold_low: 0, gap: 2, accept: 1'b1, exp_ferr: 0, exp_ovr: 0};
        vecs[3] = '{data: 8'h81, stop_bit: 1'b0, hold_low: 3, gap: 2, accept: 1'b0, exp_ferr: 1, exp_ovr: 0};
        vecs[4] = '{data: 8'h3C, stop_bit: 1'b1, hold_low: 0, gap: 2, accept: 1'b1, exp_ferr: 0, exp_ovr: 0};
        vecs[5] = '{data: 8'h6E, stop_bit: 1'b1, hold_low: 0, gap: 2, accept: 1'b1, exp_ferr: 0, exp_ovr: 0};

        reset     = 1'b0;
        serial_in = 1'b1;
        rx_ready  = 1'b0;
        wait_cycles(3);
        check_output("reset_parallel_out", int'(parallel_out), 0);
        check_output("reset_rx_valid", int'(rx_valid), 0);
        check_output("reset_fifo_count", int'(fifo_count), 0);
        check_output("reset_frame_err", int'(frame_err), 0);
        check_output("reset_overrun", int'(overrun), 0);
        reset = 1'b1;
        wait_cycles(5);
        rx_ready = 1'b1;

        for (int i = 0; i < 6; i++) begin
            ferr0 = ferr_cycles;
            ovr0 = ovr_cycles;
            last_rise = -1;
            apply_stimulus(vecs[i]);
            check_output($sformatf("vec%0d_latency", i), rise_latency(), vecs[i].accept ? LAT : -1);
            check_output($sformatf("vec%0d_frame_err", i), ferr_cycles - ferr0, vecs[i].exp_ferr);
            check_output($sformatf("vec%0d_overrun", i), ovr_cycles - ovr0, vecs[i].exp_ovr);
            check_output($sformatf("vec%0d_fifo_count", i), int'(fifo_count), 0);
        end

        // A short low pulse must be rejected. A real frame follows it.
        ferr0 = ferr_cycles;
        last_rise = -1;
        serial_in = 1'b0;
        wait_cycles(20);
        serial_in = 1'b1;
        wait_cycles(2 * CPB);
        check_output("glitch_no_valid", last_rise, -1);
        check_output("glitch_no_frame_err", ferr_cycles - ferr0, 0);
        check_output("glitch_fifo_count", int'(fifo_count), 0);
        v = '{data: 8'hA5, stop_bit: 1'b1, hold_low: 0, gap: 2, accept: 1'b1, exp_ferr: 0, exp_ovr: 0};
        apply_stimulus(v);
        check_output("a5_latency", rise_latency(), LAT);
        check_output("a5_fifo_count", int'(fifo_count), 0);

        // Overrun: five back-to-back frames with no consumer. The fifth byte is dropped.
        rx_ready = 1'b0;
        ovr0 = ovr_cycles;
        for (int d = 1; d <= 5; d++) begin
            v = '{data: 8'(d), stop_bit: 1'b1, hold_low: 0, gap: (d == 5) ? 2 : 0,
                  accept: (d <= 4), exp_ferr: 0, exp_ovr: 0};
            apply_stimulus(v);
        end
        check_output("ovr_fifo_count", int'(fifo_count), 4);
        check_output("ovr_pulses", ovr_cycles - ovr0, 1);
        check_output("ovr_head", int'(parallel_out), int'(sb[0]));

        // Collision: the FIFO is full and a single pop lands exactly on the stop decision.
        ovr0 = ovr_cycles;
        v = '{data: 8'h06, stop_bit: 1'b1, hold_low: 0, gap: 2, accept: 1'b1, exp_ferr: 0, exp_ovr: 0};
        fork
            apply_stimulus(v);
            begin
                wait_cycles(LAT - 1);
                rx_ready = 1'b1;
                wait_cycles(1);
                rx_ready = 1'b0;
            end
        join
        check_output("coll_overrun", ovr_cycles - ovr0, 0);
        check_output("coll_fifo_count", int'(fifo_count), 4);

        // Single pop: the next entry falls through and the count drops by one.
        rx_ready = 1'b1;
        wait_cycles(1);
        rx_ready = 1'b0;
        check_output("pop_head", int'(parallel_out), int'(sb[0]));
        check_output("pop_fifo_count", int'(fifo_count), 3);
        rx_ready = 1'b1;
        wait_cycles(10);
        check_output("drain_fifo_count", int'(fifo_count), 0);
        check_output("drain_sb_left", sb.size(), 0);

        // Reset during data bit 4 while one byte waits in the FIFO.
        rx_ready = 1'b0;
        v = '{data: 8'h77, stop_bit: 1'b1, hold_low: 0, gap: 1, accept: 1'b1, exp_ferr: 0, exp_ovr: 0};
        apply_stimulus(v);
        check_output("pre_reset_fifo_count", int'(fifo_count), 1);
        ferr0 = ferr_cycles;
        ovr0 = ovr_cycles;
        last_rise = -1;
        v = '{data: 8'hF0, stop_bit: 1'b1, hold_low: 0, gap: 2, accept: 1'b0, exp_ferr: 0, exp_ovr: 0};
        fork
            apply_stimulus(v);
            begin
                wait_cycles(5 * CPB + HALF);
                reset = 1'b0;
                sb.delete();
                wait_cycles(1);
                check_output("mid_reset_parallel_out", int'(parallel_out), 0);
                check_output("mid_reset_rx_valid", int'(rx_valid), 0);
                check_output("mid_reset_fifo_count", int'(fifo_count), 0);
                check_output("mid_reset_frame_err", int'(frame_err), 0);
                check_output("mid_reset_overrun", int'(overrun), 0);
                reset = 1'b1;
            end
        join
        check_output("after_reset_no_valid", last_rise, -1);
        check_output("after_reset_frame_err", ferr_cycles - ferr0, 0);
        check_output("after_reset_overrun", ovr_cycles - ovr0, 0);
        rx_ready = 1'b1;
        v = '{data: 8'hC3, stop_bit: 1'b1, hold_low: 0, gap: 2, accept: 1'b1, exp_ferr: 0, exp_ovr: 0};
        apply_stimulus(v);
        check_output("c3_latency", rise_latency(), LAT);
        check_output("c3_fifo_count", int'(fifo_count), 0);
        check_output("final_sb_left", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_rx_buffered.md
# uart_rx_buffered

Buffered UART receive endpoint: deserialises 8N1 frames arriving on `serial_in` (normally driven by the team's `transmitter`) into bytes, with the following checks and buffering:

- 2-FF input synchronisation
- glitch-rejecting start detection and 3-sample majority voting per bit
- stop-bit framing check
- a small first-word-fall-through FIFO with a valid/ready consumer handshake

It sits at the pin-side receive path of the serial link, so downstream logic never loses bytes to momentary back-pressure.

## Interface
- `CLK_HZ`, 100000000, system clock frequency in Hz
- `BIT_RATE`, 115200, line bit rate in bit/s
- `PAYLOAD_BITS`, 8, data bits per frame (LSB first)
- `FIFO_DEPTH`, 4, receive FIFO entries (power of two, ≥2)
- Derived values: `CLKS_PER_BIT` = CLK_HZ/BIT_RATE (integer divide, 868 at defaults); `HALF` = CLKS_PER_BIT/2 (434)
- `clk`  input  1  single system clock; all logic rising-edge
- `reset`  input  1  synchronous, active-low reset, sampled on `clk`
- `serial_in`  input  1  asynchronous serial line, idle high
- `parallel_out`  output  PAYLOAD_BITS  FIFO head byte, valid while `rx_valid`=1
- `rx_valid`  output  1  FIFO non-empty
- `rx_ready`  input  1  consumer accepts head; pop occurs when `rx_valid && rx_ready`
- `frame_err`  output  1  one-cycle pulse: stop bit sampled low
- `overrun`  output  1  one-cycle pulse: good byte dropped because FIFO was full
- `fifo_count`  output  clog2(FIFO_DEPTH)+1  current FIFO occupancy

## Operation
- **Synchroniser:** `serial_in` → sync1 → sync2. Both stages reset to 1. FSM sees only sync2.
- **Bit counter `cnt`:** set to 0 on every state entry. Counts 0..CLKS_PER_BIT-1, then wraps to 0.
- **Majority sampling:** sync2 is sampled at `cnt` = HALF-1, HALF and HALF+1. The voted value is resolved at `cnt` = HALF+1 (2-of-3).
- FSM states: IDLE, START, DATA, STOP, WAIT_IDLE.
  - **IDLE:** sync2=0 → START.
  - **START:**
    - At `cnt` = HALF+1: vote = 1 → IDLE (glitch rejected, nothing reported).
    - Vote = 0 → stay. At `cnt` = CLKS_PER_BIT-1 → DATA, with bit index 0.
  - **DATA:**
    - At `cnt` = HALF+1: shift the vote into the shift register, LSB first (bit 0 arrives first).
    - At `cnt` = CLKS_PER_BIT-1: if index = PAYLOAD_BITS-1 → STOP, else increment the index.
  - **STOP:** decision at `cnt` = HALF+1 (the FSM does not wait for the end of the stop bit):
    - Vote = 1 and FIFO has space → push the byte, → IDLE.
    - Vote = 1 and FIFO full with no pop this cycle → drop the byte, pulse `overrun`, → IDLE.
    - Vote = 0 → pulse `frame_err`, discard the byte, → WAIT_IDLE.
  - **WAIT_IDLE:** remain until sync2=1, then → IDLE. A held-low line (break) therefore produces exactly one `frame_err`.
- **FIFO:**
  - Circular buffer with read/write pointers and a count.
  - `parallel_out` = memory[rd_ptr], combinational from registered state (first-word fall-through).
  - Push and pop in the same cycle: both take effect and the count is unchanged. This applies when full too: the pop frees the slot and no overrun is raised.
  - Pop when empty is ignored.
  - Pointers wrap modulo FIFO_DEPTH.
- **Reset** (reset=0 at a clock edge), including mid-frame:
  - State → IDLE, `cnt` = 0, bit index = 0, shift register = 0
  - FIFO emptied
  - Sync stages → 1
  - Outputs: `parallel_out` = 0, `rx_valid` = 0, `fifo_count` = 0, `frame_err` = 0, `overrun` = 0
  - A frame in flight is lost without error pulses.

## Timing
- Let S be the first edge at which the FSM sees sync2=0, two edges after `serial_in` is first sampled low.
- START is entered at S with `cnt` = 0. The stop decision is made at edge S+9·CLKS_PER_BIT+HALF+1.
- `rx_valid` goes high after the following edge: S+9·CLKS_PER_BIT+HALF+2, i.e. S+8248 at defaults.
- `frame_err` and `overrun` are high for exactly the one cycle following the decision edge.
- The next frame can be detected from the cycle after the STOP decision. This tolerates a transmitter clock up to ~5% fast.
- Pop latency: after an edge with `rx_valid && rx_ready`, `parallel_out` shows the next entry and `fifo_count` is decremented.

## Test plan
- **Single byte:** idle line, send frame 0x55 at 868 clk/bit, `rx_ready`=1 → `rx_valid` at S+8248, `parallel_out`=0x55, popped next cycle, `fifo_count` back to 0.
- **Glitch:** 200-cycle low pulse on idle line → returns to IDLE at `cnt`=HALF+1, no push, no `frame_err`. Then a 0xA5 frame → 0xA5 received.
- **Framing error:** frame 0x81 with stop bit low, line held low a further 3 bit times → exactly one `frame_err` pulse, `fifo_count` stays 0. After the line returns high, 0x3C → received 0x3C.
- **Overrun:** `rx_ready`=0, five back-to-back frames 0x01..0x05 → `fifo_count`=4, one `overrun` pulse on the 5th. Then `rx_ready`=1 drains 0x01,0x02,0x03,0x04 in order.
- **Full push/pop collision:** FIFO full, `rx_ready`=1 in the exact STOP decision cycle → byte accepted, no `overrun`, `fifo_count` stays 4.
- **Reset mid-frame:** reset=0 for one edge during DATA bit 4 → all outputs 0. The remainder of the frame causes no push, or at most a glitch reject; the next clean 0xC3 frame is received correctly.
